ct_lsu_st_sf_req_gen: RTL

//  Store-pipe producer of the spec-fail training/check interface. Registers store DC-stage results into a DA-stage holding register.

---
 rtl/ct_lsu_st_sf_req_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/ct_lsu_st_sf_req_gen.sv
// Store-pipe spec-fail request generator: DC->DA holding register plus one-shot train/check pulses.
// Optional LSU_SF_DUP_FILTER_EN adds a single-entry cooldown filter against repeated training.
module ct_lsu_st_sf_req_gen #(
    parameter int unsigned COOLDOWN = 8
) (
    input  logic        sf_clk,
    input  logic        cpurst_b,
    input  logic        rtu_yy_xx_flush,
    input  logic        st_dc_sf_vld,
    input  logic        st_dc_stall,
    input  logic [35:0] st_dc_addr_tto4,
    input  logic [15:0] st_dc_bytes_vld,
    input  logic [6:0]  st_dc_iid,
    input  logic        st_dc_spec_fail,
    input  logic        st_dc_mark_hit,
    output logic [35:0] st_da_sf_addr_tto4,
    output logic [15:0] st_da_sf_bytes_vld,
    output logic [6:0]  st_da_sf_iid,
    output logic        st_da_sf_no_spec_miss,
    output logic        st_da_sf_no_spec_miss_gate,
    output logic        st_da_sf_spec_chk,
    output logic        st_da_sf_spec_chk_gate
);

    logic        r_da_vld;
    logic        r_da_issued;
    logic [35:0] r_da_addr;
    logic [15:0] r_da_bytes;
    logic [6:0]  r_da_iid;
    logic        r_da_spec_fail;
    logic        r_da_mark_hit;

    logic        w_evt;
    logic        w_filt_hit;
    logic        w_no_spec_miss;

    assign w_evt          = r_da_vld & ~r_da_issued;
    assign w_no_spec_miss = w_evt & r_da_spec_fail & ~w_filt_hit;

    // Flush beats capture; capture beats the issued-set so a fresh store always gets its own event.
    always_ff @(posedge sf_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_da_vld       <= 1'b0;
            r_da_issued    <= 1'b0;
            r_da_addr      <= '0;
            r_da_bytes     <= '0;
            r_da_iid       <= '0;
            r_da_spec_fail <= 1'b0;
            r_da_mark_hit  <= 1'b0;
        end else begin
            if (w_evt) begin
                r_da_issued <= 1'b1;
            end
            if (rtu_yy_xx_flush) begin
                r_da_vld    <= 1'b0;
                r_da_issued <= 1'b0;
            end else if (!st_dc_stall) begin
                if (st_dc_sf_vld) begin
                    r_da_vld       <= 1'b1;
                    r_da_issued    <= 1'b0;
                    r_da_addr      <= st_dc_addr_tto4;
                    r_da_bytes     <= st_dc_bytes_vld;
                    r_da_iid       <= st_dc_iid;
                    r_da_spec_fail <= st_dc_spec_fail;
                    r_da_mark_hit  <= st_dc_mark_hit;
                end else begin
                    r_da_vld <= 1'b0;
                end
            end
        end
    end

`ifdef LSU_SF_DUP_FILTER_EN
    localparam logic [3:0] LP_COOLDOWN = 4'(COOLDOWN);

    logic [35:0] r_filt_addr;
    logic [3:0]  r_cnt;

    // Filter state is deliberately untouched by flush.
    always_ff @(posedge sf_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_filt_addr <= '0;
            r_cnt       <= '0;
        end else if (w_no_spec_miss) begin
            r_filt_addr <= r_da_addr;
            r_cnt       <= LP_COOLDOWN;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign w_filt_hit = (r_cnt != 4'd0) && (r_da_addr == r_filt_addr);
`else
    assign w_filt_hit = 1'b0;
`endif

    assign st_da_sf_addr_tto4         = r_da_addr;
    assign st_da_sf_bytes_vld         = r_da_bytes;
    assign st_da_sf_iid               = r_da_iid;
    assign st_da_sf_no_spec_miss      = w_no_spec_miss;
    assign st_da_sf_spec_chk          = w_evt & r_da_mark_hit;
    assign st_da_sf_no_spec_miss_gate = r_da_vld & r_da_spec_fail;
    assign st_da_sf_spec_chk_gate     = r_da_vld & r_da_mark_hit;

endmodule
